pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 98 +++++++++
 tb/tb_pipe_hazard_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forwarding control for a 5-stage pipeline with a memory-wait FSM.
// Define HAZARD_PERF_EN to add the stall_cycles/flush_count performance counters.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  id_rn,
    input  logic [3:0]  id_rm,
    input  logic        id_rn_used,
    input  logic        id_rm_used,
    input  logic [3:0]  ex_rd,
    input  logic        ex_rwrite,
    input  logic        ex_is_load,
    input  logic [3:0]  mem_rd,
    input  logic        mem_rwrite,
    input  logic [3:0]  wb_rd,
    input  logic        wb_rwrite,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ack,
    output logic        stall_if,
    output logic        stall_id,
    output logic        stall_ex,
    output logic        stall_mem,
    output logic        flush_id,
    output logic        flush_ex,
    output logic        flush_mem,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
`ifdef HAZARD_PERF_EN
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count,
`endif
    output logic        mem_err
);
    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t     state, state_nx;
    logic [7:0] cnt;
    logic       run, waiting, timeout, freeze, hit_rn, hit_rm, lu, br;

    // r15 is the PC: never a forwarding or load-use source
    function automatic logic [1:0] fwd_sel(input logic [3:0] src, input logic used,
                                           input logic [3:0] m_rd, input logic m_w,
                                           input logic [3:0] w_rd, input logic w_w);
        return (!used || src == 4'hF) ? 2'b00 :
               (m_w && m_rd == src)   ? 2'b01 :
               (w_w && w_rd == src)   ? 2'b10 : 2'b00;
    endfunction

    always_comb begin
        run      = reset && state == RUN;
        waiting  = reset && state == MEM_WAIT;
        timeout  = waiting && !mem_ack && cnt == 8'(MEM_TIMEOUT);
        freeze   = waiting && !mem_ack && !timeout;
        hit_rn   = id_rn_used && id_rn != 4'hF && id_rn == ex_rd;
        hit_rm   = id_rm_used && id_rm != 4'hF && id_rm == ex_rd;
        lu       = run && ex_is_load && ex_rwrite && (hit_rn || hit_rm);
        br       = run && ex_branch_taken;
        stall_if  = freeze || (lu && !br);
        stall_id  = freeze || (lu && !br);
        stall_ex  = freeze;
        stall_mem = freeze;
        flush_id  = br;
        flush_ex  = br || lu;
        flush_mem = timeout;
        mem_err   = timeout;
        fwd_a     = fwd_sel(id_rn, id_rn_used, mem_rd, mem_rwrite, wb_rd, wb_rwrite);
        fwd_b     = fwd_sel(id_rm, id_rm_used, mem_rd, mem_rwrite, wb_rd, wb_rwrite);
        state_nx  = (state == RUN) ? ((mem_req && !mem_ack) ? MEM_WAIT : RUN)
                                   : ((mem_ack || timeout) ? RUN : MEM_WAIT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= 8'd0;
        end else begin
            state <= state_nx;
            cnt   <= (state == RUN) ? 8'd0 : (mem_ack ? cnt : cnt + 8'd1);
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= 16'd0;
            flush_count  <= 16'd0;
        end else begin
            if ((stall_if || stall_id || stall_ex || stall_mem) && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 16'd1;
            if ((flush_id || flush_mem) && flush_count != 16'hFFFF)
                flush_count <= flush_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed plus random checks of pipe_hazard_ctrl against a rule-level model.
module tb_pipe_hazard_ctrl;
    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] id_rn, id_rm, ex_rd, mem_rd, wb_rd;
    logic       id_rn_used, id_rm_used, ex_rwrite, ex_is_load, mem_rwrite, wb_rwrite;
    logic       ex_branch_taken, mem_req, mem_ack;
    logic       stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_mem, mem_err;
    logic [1:0] fwd_a, fwd_b;
`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cycles, flush_count;
`endif

    int n_chk = 0;
    int n_err = 0;
    bit m_wait = 0;
    int m_waited = 0;
    int m_sc = 0;
    int m_fc = 0;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .id_rn(id_rn), .id_rm(id_rm), .id_rn_used(id_rn_used), .id_rm_used(id_rm_used),
        .ex_rd(ex_rd), .ex_rwrite(ex_rwrite), .ex_is_load(ex_is_load),
        .mem_rd(mem_rd), .mem_rwrite(mem_rwrite), .wb_rd(wb_rd), .wb_rwrite(wb_rwrite),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
        .flush_id(flush_id), .flush_ex(flush_ex), .flush_mem(flush_mem),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
`ifdef HAZARD_PERF_EN
        .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [3:0] src, input logic used);
        if (!used || src == 4'd15) return 2'd0;
        if (mem_rwrite && mem_rd == src) return 2'd1;
        if (wb_rwrite && wb_rd == src) return 2'd2;
        return 2'd0;
    endfunction

    // Check outputs mid-cycle against the model, then advance the model on the clock edge.
    task automatic tick(input string tag);
        logic [3:0] e_st;
        logic [2:0] e_fl;
        logic       e_err, lu, tmo, frz;
        @(negedge clk);
        tmo = m_wait && !mem_ack && m_waited == TO;
        frz = m_wait && !mem_ack && !tmo;
        lu  = ex_is_load && ex_rwrite &&
              ((id_rn_used && id_rn != 4'd15 && id_rn == ex_rd) ||
               (id_rm_used && id_rm != 4'd15 && id_rm == ex_rd));
        e_st  = frz ? 4'b1111 : (!m_wait && !ex_branch_taken && lu) ? 4'b0011 : 4'b0000;
        e_fl  = tmo ? 3'b100 : m_wait ? 3'b000 : ex_branch_taken ? 3'b011 : lu ? 3'b010 : 3'b000;
        e_err = tmo;
        if (!reset) begin
            e_st = 0; e_fl = 0; e_err = 0;
        end
        chk({tag, ".stall"}, {12'd0, stall_mem, stall_ex, stall_id, stall_if}, {12'd0, e_st});
        chk({tag, ".flush"}, {13'd0, flush_mem, flush_ex, flush_id}, {13'd0, e_fl});
        chk({tag, ".mem_err"}, {15'd0, mem_err}, {15'd0, e_err});
        chk({tag, ".fwd_a"}, {14'd0, fwd_a}, {14'd0, ref_fwd(id_rn, id_rn_used)});
        chk({tag, ".fwd_b"}, {14'd0, fwd_b}, {14'd0, ref_fwd(id_rm, id_rm_used)});
`ifdef HAZARD_PERF_EN
        chk({tag, ".stall_cycles"}, stall_cycles, 16'(m_sc));
        chk({tag, ".flush_count"}, flush_count, 16'(m_fc));
`endif
        @(posedge clk);
        if (!reset) begin
            m_wait = 0; m_waited = 0; m_sc = 0; m_fc = 0;
        end else begin
            if (e_st != 0 && m_sc < 65535) m_sc++;
            if ((e_fl[0] || e_fl[2]) && m_fc < 65535) m_fc++;
            if (!m_wait) begin
                if (mem_req && !mem_ack) begin
                    m_wait = 1; m_waited = 0;
                end
            end else if (mem_ack || tmo) m_wait = 0;
            else m_waited++;
        end
        #1;
    endtask

    task automatic clear_in();
        {id_rn, id_rm, ex_rd, mem_rd, wb_rd} = '0;
        {id_rn_used, id_rm_used, ex_rwrite, ex_is_load, mem_rwrite, wb_rwrite} = '0;
        {ex_branch_taken, mem_req, mem_ack} = '0;
    endtask

    task automatic mem_access(input int stalls);
        mem_req = 1; mem_ack = 0;
        tick("enter");
        repeat (stalls) tick("wait");
        mem_ack = 1;
        tick("ack");
        mem_req = 0; mem_ack = 0;
    endtask

    function automatic logic [3:0] pick();
        return ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
    endfunction

    initial begin
        clear_in();
        reset = 0;
        ex_branch_taken = 1; mem_req = 1;
        mem_rwrite = 1; mem_rd = 2; id_rn = 2; id_rn_used = 1;
        #1;
        tick("reset0");
        tick("reset1");
        clear_in();
        reset = 1;
        tick("idle");

        ex_is_load = 1; ex_rwrite = 1; ex_rd = 3; id_rn = 3; id_rn_used = 1;
        tick("loaduse");
        ex_is_load = 0;
        tick("loaduse_done");
        id_rn = 15; ex_rd = 15; ex_is_load = 1;
        tick("loaduse_pc");
        id_rn_used = 0; ex_rd = 3; id_rn = 3;
        tick("loaduse_unused");
        clear_in();

        mem_rd = 5; wb_rd = 5; mem_rwrite = 1; wb_rwrite = 1; id_rm = 5; id_rm_used = 1;
        tick("fwd_exmem");
        mem_rwrite = 0;
        tick("fwd_memwb");
        id_rm = 15; mem_rd = 15; wb_rd = 15;
        tick("fwd_pc");
        clear_in();

        ex_is_load = 1; ex_rwrite = 1; ex_rd = 7; id_rm = 7; id_rm_used = 1; ex_branch_taken = 1;
        tick("branch_lu");
        clear_in();

        mem_access(3);
        tick("after_ack");
        mem_access(TO);

        mem_req = 1;
        tick("to_enter");
        repeat (TO) tick("to_wait");
        tick("to_abort");
        mem_req = 0;
        tick("to_run");

        mem_req = 1; ex_branch_taken = 1;
        tick("br_enter");
        repeat (2) tick("br_wait");
        mem_ack = 1;
        tick("br_ack");
        mem_req = 0; mem_ack = 0;
        tick("br_run");
        clear_in();

        mem_req = 1;
        repeat (3) tick("rst_wait");
        reset = 0;
        tick("rst_mid");
        reset = 1; mem_req = 0;
        tick("rst_after");

        reset = 0;
        tick("perf_rst");
        reset = 1;
        mem_access(3); mem_access(3); mem_access(3); mem_access(1);
        ex_branch_taken = 1;
        tick("perf_br");
        ex_branch_taken = 0;
        tick("perf_end");
`ifdef HAZARD_PERF_EN
        chk("perf_stall10", stall_cycles, 16'd10);
        chk("perf_flush1", flush_count, 16'd1);
`endif

        for (int i = 0; i < 400; i++) begin
            id_rn = pick(); id_rm = pick(); ex_rd = pick(); mem_rd = pick(); wb_rd = pick();
            id_rn_used = 1'($urandom); id_rm_used = 1'($urandom);
            ex_rwrite = 1'($urandom); ex_is_load = 1'($urandom);
            mem_rwrite = 1'($urandom); wb_rwrite = 1'($urandom);
            ex_branch_taken = ($urandom_range(0, 4) == 0);
            mem_req = ($urandom_range(0, 3) == 0);
            mem_ack = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 59) != 0);
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
